bar_sort_engine: RTL and testbench

- Bubble-sort engine that owns the array of bar heights and updates it one comparison or swap per animation tick.
- It writes the array that the bar renderer reads every frame to draw its pixels; the renderer is purely combinational.
- Exposes the packed array, the current compare index and a swap highlight so the renderer can colour the active pair.

---
 rtl/bar_sort_if.sv | 27 ++
 rtl/bar_sort_engine.sv | 131 +++++++++++++
 tb/tb_bar_sort_engine.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bar_sort_if.sv
// Handshake/data bundle between the bubble-sort engine and its driver/renderer.
// The engine uses the slave modport; the stimulus side uses master.
interface bar_sort_if #(
  parameter int N = 10,
  parameter int W = 6
);
  logic           load;
  logic [N*W-1:0] load_data;
  logic           start;
  logic           step_en;
  logic [N*W-1:0] array_data;
  logic [3:0]     cmp_idx;
  logic           swap_flag;
  logic           busy;
  logic           done;
  logic [3:0]     pass_cnt;

  modport master (
    output load, load_data, start, step_en,
    input  array_data, cmp_idx, swap_flag, busy, done, pass_cnt
  );

  modport slave (
    input  load, load_data, start, step_en,
    output array_data, cmp_idx, swap_flag, busy, done, pass_cnt
  );
endinterface

// File: rtl/bar_sort_engine.sv
// Bubble-sort engine owning the bar-height array; one compare or one swap per
// animation tick so the renderer can show every step of the sort.
module bar_sort_engine #(
  parameter int N = 10,
  parameter int W = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  bar_sort_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_SWAP, S_DONE} state_t;

  localparam logic [3:0] LIM_FULL = 4'(N-1);

  state_t                r_state, w_state;
  logic [N-1:0][W-1:0]   r_arr, w_arr;
  logic [3:0]            r_j, w_j;
  logic [3:0]            r_limit, w_limit;
  logic                  r_swapped, w_swapped;
  logic [3:0]            r_pass, w_pass;

  logic [W-1:0]          w_a_lo, w_a_hi;
  logic [N-1:0][W-1:0]   w_arr_swp;
  logic                  w_do_adv, w_adv_sw, w_last;

  // Select the active pair and build the exchanged array without an
  // out-of-range variable index when j sits at the top of the array.
  always_comb begin
    w_a_lo    = '0;
    w_a_hi    = '0;
    w_arr_swp = r_arr;
    for (int i = 0; i < N-1; i++) begin
      if (r_j == 4'(i)) begin
        w_a_lo         = r_arr[i];
        w_a_hi         = r_arr[i+1];
        w_arr_swp[i]   = r_arr[i+1];
        w_arr_swp[i+1] = r_arr[i];
      end
    end
  end

  assign w_last = (r_j >= (r_limit - 4'd1));

  always_comb begin
    w_state   = r_state;
    w_arr     = r_arr;
    w_j       = r_j;
    w_limit   = r_limit;
    w_swapped = r_swapped;
    w_pass    = r_pass;
    w_do_adv  = 1'b0;
    w_adv_sw  = r_swapped;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.load) begin
          w_arr   = bus.load_data;
          w_pass  = '0;
          w_j     = '0;
          w_state = S_IDLE;
        end else if (bus.start) begin
          w_j       = '0;
          w_limit   = LIM_FULL;
          w_swapped = 1'b0;
          w_pass    = '0;
          w_state   = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (bus.step_en) begin
          if (w_a_lo > w_a_hi) w_state  = S_SWAP;
          else                 w_do_adv = 1'b1;
        end
      end
      S_SWAP: begin
        if (bus.step_en) begin
          w_arr     = w_arr_swp;
          w_swapped = 1'b1;
          w_adv_sw  = 1'b1;
          w_do_adv  = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // End of a pass with no swap (or a single remaining pair) means sorted.
    if (w_do_adv) begin
      if (!w_last) begin
        w_j     = r_j + 4'd1;
        w_state = S_COMPARE;
      end else begin
        w_pass = r_pass + 4'd1;
        w_j    = '0;
        if (!w_adv_sw || r_limit == 4'd1) begin
          w_state = S_DONE;
        end else begin
          w_limit   = r_limit - 4'd1;
          w_swapped = 1'b0;
          w_state   = S_COMPARE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_arr     <= '0;
      r_j       <= '0;
      r_limit   <= LIM_FULL;
      r_swapped <= 1'b0;
      r_pass    <= '0;
    end else begin
      r_state   <= w_state;
      r_arr     <= w_arr;
      r_j       <= w_j;
      r_limit   <= w_limit;
      r_swapped <= w_swapped;
      r_pass    <= w_pass;
    end
  end

  assign bus.array_data = r_arr;
  assign bus.cmp_idx    = r_j;
  assign bus.swap_flag  = (r_state == S_SWAP);
  assign bus.busy       = (r_state == S_COMPARE) || (r_state == S_SWAP);
  assign bus.done       = (r_state == S_DONE);
  assign bus.pass_cnt   = r_pass;

endmodule

// File: tb/tb_bar_sort_engine.sv
// Bench for bar_sort_engine: a nested-loop bubble-sort reference produces the
// expected output snapshot after every tick; outputs are compared each cycle.
module tb_bar_sort_engine;
  localparam int N = 10;
  localparam int W = 6;

  typedef struct packed {
    logic [N*W-1:0] arr;
    logic [3:0]     j;
    logic           sf;
    logic           busy;
    logic           done;
    logic [3:0]     pass;
  } snap_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bar_sort_if #(.N(N), .W(W)) bus ();
  bar_sort_engine #(.N(N), .W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int    n_assert = 0;
  int    n_fail   = 0;
  snap_t exp_s;
  snap_t trace[$];
  int    idx;
  bit    chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int a[N]);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(a[i]);
    return r;
  endfunction

  function automatic snap_t mk(input int a[N], input int j, input bit sf,
                               input bit busy, input bit done, input int pass);
    snap_t s;
    s.arr = pack(a); s.j = 4'(j); s.sf = sf;
    s.busy = busy; s.done = done; s.pass = 4'(pass);
    return s;
  endfunction

  // Expected snapshot after start (index 0) and after each tick (index k).
  task automatic build_trace(input logic [N*W-1:0] ld);
    int a[N];
    int pass, t;
    bit sw, fin;
    for (int i = 0; i < N; i++) a[i] = int'(ld[i*W +: W]);
    trace.delete();
    trace.push_back(mk(a, 0, 0, 1, 0, 0));
    pass = 0; fin = 0;
    for (int lim = N-1; lim >= 1 && !fin; lim--) begin
      sw = 0;
      for (int j = 0; j < lim; j++) begin
        if (a[j] > a[j+1]) begin
          trace.push_back(mk(a, j, 1, 1, 0, pass));
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          sw = 1;
        end
        if (j < lim-1) trace.push_back(mk(a, j+1, 0, 1, 0, pass));
        else begin
          pass++;
          if (!sw || lim == 1) begin
            trace.push_back(mk(a, 0, 0, 0, 1, pass));
            fin = 1;
          end else trace.push_back(mk(a, 0, 0, 1, 0, pass));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("array_data", 64'(bus.array_data), 64'(exp_s.arr));
      chk("cmp_idx",    64'(bus.cmp_idx),    64'(exp_s.j));
      chk("swap_flag",  64'(bus.swap_flag),  64'(exp_s.sf));
      chk("busy",       64'(bus.busy),       64'(exp_s.busy));
      chk("done",       64'(bus.done),       64'(exp_s.done));
      chk("pass_cnt",   64'(bus.pass_cnt),   64'(exp_s.pass));
    end
  end

  int sf_seen;

  task automatic pulse(input bit ld, input bit st, input bit se, input logic [N*W-1:0] d);
    @(negedge clk);
    bus.load = ld; bus.start = st; bus.step_en = se; bus.load_data = d;
    @(posedge clk);
    #1;
    bus.load = 0; bus.start = 0; bus.step_en = 0;
  endtask

  task automatic do_load(input logic [N*W-1:0] d);
    pulse(1, 0, 0, d);
    exp_s = '{arr: d, j: 4'd0, sf: 1'b0, busy: 1'b0, done: 1'b0, pass: 4'd0};
    build_trace(d);
  endtask

  task automatic do_start();
    pulse(0, 1, 0, '0);
    idx = 0;
    exp_s = trace[0];
  endtask

  task automatic step();
    pulse(0, 0, 1, '0);
    if (idx + 1 < trace.size()) idx++;
    else chk("trace_overrun", 64'(idx + 1), 64'(trace.size() - 1));
    exp_s = trace[idx];
    if (bus.swap_flag) sf_seen++;
  endtask

  task automatic run_sort(input int gap, output int nsteps);
    nsteps = 0;
    while (!exp_s.done && nsteps < trace.size() + 2) begin
      repeat (gap - 1) @(negedge clk);
      step();
      nsteps++;
    end
    @(negedge clk);
    chk("sort_done", 64'(bus.done), 64'd1);
  endtask

  int a_sorted[N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
  int a_rev[N]    = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
  int a_312[N]    = '{3, 1, 2, 4, 5, 6, 7, 8, 9, 10};
  int a_dup[N]    = '{5, 5, 0, 0, 0, 0, 0, 0, 0, 0};
  int a_dup_s[N]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 5};
  int a_13[N]     = '{1, 3, 2, 4, 5, 6, 7, 8, 9, 10};

  initial begin
    int ns, cnt;
    bus.load = 0; bus.start = 0; bus.step_en = 0; bus.load_data = '0;
    reset_n = 1'b0;
    exp_s = '0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Sorted input: single pass, never a swap.
    do_load(pack(a_sorted));
    chk("model_sorted_len", 64'(trace.size()), 64'd10);
    do_start();
    sf_seen = 0;
    run_sort(1, ns);
    chk("sorted_steps", 64'(ns), 64'd9);
    chk("sorted_sf", 64'(sf_seen), 64'd0);
    chk("sorted_pass", 64'(bus.pass_cnt), 64'd1);
    chk("sorted_arr", 64'(bus.array_data), 64'(pack(a_sorted)));

    // Reverse input, tick every 4th cycle.
    do_load(pack(a_rev));
    cnt = 0;
    foreach (trace[k]) if (trace[k].sf) cnt++;
    chk("model_rev_len", 64'(trace.size()), 64'd91);
    chk("model_rev_sf", 64'(cnt), 64'd45);
    chk("model_rev_pass", 64'(trace[trace.size()-1].pass), 64'd9);
    do_start();
    sf_seen = 0;
    run_sort(4, ns);
    chk("rev_steps", 64'(ns), 64'd90);
    chk("rev_sf", 64'(sf_seen), 64'd45);
    chk("rev_pass", 64'(bus.pass_cnt), 64'd9);
    chk("rev_arr", 64'(bus.array_data), 64'(pack(a_sorted)));

    // Restart from DONE: already sorted, one pass.
    build_trace(bus.array_data);
    do_start();
    run_sort(2, ns);
    chk("resort_steps", 64'(ns), 64'd9);

    // [3,1,2,...]: first swap visible step by step; busy-time load/start ignored.
    do_load(pack(a_312));
    chk("model_312_sf", 64'(trace[1].sf), 64'd1);
    chk("model_312_arr2", 64'(trace[2].arr), 64'(pack(a_13)));
    do_start();
    step();
    chk("312_sf1", 64'(bus.swap_flag), 64'd1);
    chk("312_idx1", 64'(bus.cmp_idx), 64'd0);
    chk("312_arr1", 64'(bus.array_data), 64'(pack(a_312)));
    step();
    chk("312_sf2", 64'(bus.swap_flag), 64'd0);
    chk("312_idx2", 64'(bus.cmp_idx), 64'd1);
    chk("312_arr2", 64'(bus.array_data), 64'(pack(a_13)));
    pulse(0, 1, 0, '0);
    pulse(1, 0, 0, pack(a_rev));
    chk("busy_ignore_idx", 64'(bus.cmp_idx), 64'd1);
    run_sort(1, ns);
    chk("312_pass", 64'(bus.pass_cnt), 64'd2);

    // Duplicates stay put and never swap.
    do_load(pack(a_dup));
    chk("model_dup_sf", 64'(trace[1].sf), 64'd0);
    chk("model_dup_final", 64'(trace[trace.size()-1].arr), 64'(pack(a_dup_s)));
    do_start();
    step();
    chk("dup_first_sf", 64'(bus.swap_flag), 64'd0);
    run_sort(1, ns);
    chk("dup_arr", 64'(bus.array_data), 64'(pack(a_dup_s)));

    // load+start together: load wins; step_en in IDLE does nothing.
    pulse(1, 1, 0, pack(a_rev));
    exp_s = '{arr: pack(a_rev), j: 4'd0, sf: 1'b0, busy: 1'b0, done: 1'b0, pass: 4'd0};
    build_trace(pack(a_rev));
    @(negedge clk);
    chk("ldst_busy", 64'(bus.busy), 64'd0);
    pulse(0, 0, 1, '0);
    pulse(0, 0, 1, '0);
    chk("idle_step_arr", 64'(bus.array_data), 64'(pack(a_rev)));

    // Reset mid-swap clears everything immediately.
    do_start();
    step();
    chk("pre_rst_sf", 64'(bus.swap_flag), 64'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_s = '0;
    #1;
    chk("rst_arr", 64'(bus.array_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sf", 64'(bus.swap_flag), 64'd0);
    chk("rst_idx", 64'(bus.cmp_idx), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_load(pack(a_312));
    do_start();
    run_sort(1, ns);
    chk("post_rst_arr", 64'(bus.array_data), 64'(pack(a_sorted)));
    chk("post_rst_pass", 64'(bus.pass_cnt), 64'd2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
